// File: rtl/rng_word_arbiter_if.sv
// Handshake bundle between the SHAKE256 squeeze stream, the word arbiter and its sampler ports.
interface rng_word_arbiter_if #(
    parameter int unsigned N_PORT = 4,
    parameter int unsigned W      = 128
);
    logic                shk_valid;
    logic [W-1:0]        shk_data;
    logic                shk_ready;
    logic [N_PORT-1:0]   rng_valid;
    logic [N_PORT*W-1:0] rng;
    logic [N_PORT-1:0]   rng_extract;

    modport master (
        output shk_valid, shk_data, rng_extract,
        input  shk_ready, rng_valid, rng
    );

    modport slave (
        input  shk_valid, shk_data, rng_extract,
        output shk_ready, rng_valid, rng
    );
endinterface

// File: rtl/rng_word_arbiter.sv
// Shares one SHAKE256 word stream among N_PORT samplers via a small FIFO and round-robin dealing.
// Optional feature macro: RNG_ARB_STAT_EN builds saturating per-port consumed-word counters.
module rng_word_arbiter #(
    parameter int unsigned N_PORT = 4,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned W      = 128
) (
    input  logic                    clk,
    input  logic                    rst,
    rng_word_arbiter_if.slave       bus,
    output logic [$clog2(DEPTH):0]  fifo_level,
    output logic                    err_extract,
    output logic [N_PORT*16-1:0]    stat_cnt
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;
    localparam int unsigned IW = $clog2(N_PORT);

    logic [W-1:0]        mem [DEPTH];
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;
    logic [IW-1:0]       rr;
    logic [N_PORT-1:0]   rng_valid_q;
    logic [N_PORT*W-1:0] rng_q;

    logic                push;
    logic                gnt_vld;
    logic [IW-1:0]       gnt_idx;
    logic [N_PORT-1:0]   need;

    assign bus.shk_ready = (fifo_level < LW'(DEPTH));
    assign bus.rng_valid = rng_valid_q;
    assign bus.rng       = rng_q;

    assign push = bus.shk_valid & bus.shk_ready;
    assign need = ~rng_valid_q | (bus.rng_extract & rng_valid_q);

    // Round-robin search starting one past the last granted port
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int unsigned k = 1; k <= N_PORT; k++) begin
            if (!gnt_vld && (fifo_level != '0) && need[(32'(rr) + k) % N_PORT]) begin
                gnt_vld = 1'b1;
                gnt_idx = IW'((32'(rr) + k) % N_PORT);
            end
        end
    end

    // Storage array carries no reset; pointers and level define what is valid
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.shk_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            rr         <= IW'(N_PORT - 1);
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (gnt_vld) begin
                rd_ptr <= rd_ptr + PW'(1);
                rr     <= gnt_idx;
            end
            fifo_level <= fifo_level + LW'(push) - LW'(gnt_vld);
        end
    end

    // Hold registers: a grant reloads the slot, a bare extract only empties it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rng_valid_q <= '0;
            rng_q       <= '0;
            err_extract <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < N_PORT; i++) begin
                if (gnt_vld && (gnt_idx == IW'(i))) begin
                    rng_valid_q[i]   <= 1'b1;
                    rng_q[i*W +: W]  <= mem[rd_ptr];
                end else if (bus.rng_extract[i]) begin
                    rng_valid_q[i]   <= 1'b0;
                end
            end
            if (|(bus.rng_extract & ~rng_valid_q)) begin
                err_extract <= 1'b1;
            end
        end
    end

`ifdef RNG_ARB_STAT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_cnt <= '0;
        end else begin
            for (int unsigned i = 0; i < N_PORT; i++) begin
                if (bus.rng_extract[i] && rng_valid_q[i] && (stat_cnt[i*16 +: 16] != 16'hFFFF)) begin
                    stat_cnt[i*16 +: 16] <= stat_cnt[i*16 +: 16] + 16'd1;
                end
            end
        end
    end
`else
    assign stat_cnt = '0;
`endif

endmodule
